// File: rtl/mb32_stream_dma_if.sv
// Stream and mb_io bus signals of mb32_stream_dma.
// master: the DMA engine side; slave: the stream sources/sinks and memory.
interface mb32_stream_dma_if #(parameter int AW = 17);
  logic          si_valid;
  logic [7:0]    si_data;
  logic          si_ready;
  logic          so_valid;
  logic [7:0]    so_data;
  logic          so_ready;
  logic [AW-3:0] m_ai;
  logic [31:0]   m_vi;
  logic [3:0]    m_bmsk;
  logic          m_we;
  logic [31:0]   m_vo;

  modport master (
    input  si_valid, si_data, so_ready, m_vo,
    output si_ready, so_valid, so_data, m_ai, m_vi, m_bmsk, m_we
  );
  modport slave (
    output si_valid, si_data, so_ready, m_vo,
    input  si_ready, so_valid, so_data, m_ai, m_vi, m_bmsk, m_we
  );
endinterface

// File: rtl/mb32_stream_dma.sv
// Byte-stream <-> 32-bit mb_io memory DMA engine.
// MB32_READBACK_EN compiles in the memory-to-stream path; without it mode=1 ends with done+err.
module mb32_stream_dma #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          err,
  mb32_stream_dma_if.master io
);

`ifdef MB32_READBACK_EN
  typedef enum logic [2:0] {IDLE, WRITE, FIN, RD_REQ, RD_LAT, RD_OUT} state_e;
`else
  typedef enum logic [2:0] {IDLE, WRITE, FIN} state_e;
`endif

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d, cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [AW-1:0] ptr_inc;

  assign ptr_inc = ptr_q + AW'(1);

`ifdef MB32_READBACK_EN
  logic [31:0] word_q, word_d;

  always_ff @(posedge clk) begin
    if (rst) word_q <= '0;
    else     word_q <= word_d;
  end
`else
  logic unused_rd;
  assign unused_rd = ^{io.m_vo, io.so_ready};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
`ifdef MB32_READBACK_EN
    word_d      = word_q;
`endif
    busy        = (state_q != IDLE);
    done        = 1'b0;
    err         = 1'b0;
    io.si_ready = 1'b0;
    io.so_valid = 1'b0;
    io.so_data  = '0;
    io.m_we     = 1'b0;
    io.m_ai     = '0;
    io.m_vi     = '0;
    io.m_bmsk   = '0;
    case (state_q)
      IDLE: if (start) begin
        ptr_d = base;
        cnt_d = len;
        err_d = 1'b0;
`ifdef MB32_READBACK_EN
        if (len == '0) state_d = FIN;
        else           state_d = mode ? RD_REQ : WRITE;
`else
        // No read path: a read request is reported as unsupported without touching the bus
        if (mode) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          state_d = (len == '0) ? FIN : WRITE;
        end
`endif
      end
      WRITE: begin
        io.si_ready = 1'b1;
        if (io.si_valid) begin
          io.m_we   = 1'b1;
          io.m_ai   = ptr_q[AW-1:2];
          io.m_bmsk = 4'b0001 << ptr_q[1:0];
          io.m_vi   = {4{io.si_data}};
          ptr_d     = ptr_inc;
          cnt_d     = cnt_q - AW'(1);
          if (cnt_q == AW'(1)) state_d = FIN;
        end
      end
`ifdef MB32_READBACK_EN
      RD_REQ: begin
        io.m_ai = ptr_q[AW-1:2];
        state_d = RD_LAT;
      end
      RD_LAT: begin
        word_d  = io.m_vo;
        state_d = RD_OUT;
      end
      RD_OUT: begin
        // so_data is a pure function of registered state, so it holds while stalled
        io.so_valid = 1'b1;
        io.so_data  = word_q[{ptr_q[1:0], 3'b000} +: 8];
        if (io.so_ready) begin
          ptr_d = ptr_inc;
          cnt_d = cnt_q - AW'(1);
          if (cnt_q == AW'(1))          state_d = FIN;
          else if (ptr_inc[1:0] == 2'd0) state_d = RD_REQ;
        end
      end
`endif
      FIN: begin
        done    = 1'b1;
        err     = err_q;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mb32_stream_dma.sv
// Directed bench for mb32_stream_dma: byte-level reference memory plus expected-write/read queues.
module tb_mb32_stream_dma;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst, start, mode;
  logic [AW-1:0] base, len;
  logic          busy, done, err;

  mb32_stream_dma_if #(.AW(AW)) io ();

  mb32_stream_dma #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base(base), .len(len),
    .busy(busy), .done(done), .err(err), .io(io)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-3:0] ai;
    logic [3:0]    bmsk;
    logic [31:0]   vi;
    logic [AW-1:0] addr;
    logic [7:0]    b;
  } wr_t;

  int n_cmp = 0, n_bad = 0;
  int n_done = 0, n_err = 0, exp_done = 0, exp_err = 0;

  logic [31:0] mem [0:(1<<(AW-2))-1];
  logic [7:0]  refm [0:(1<<AW)-1];
  wr_t         exp_wr[$], dut_wr[$];
  logic [7:0]  exp_rd[$], dut_so[$];
  logic [7:0]  wq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  task automatic bad(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event, want none", nm);
  endtask

  // mb_io slave: byte-masked writes, read data one clock after the address
  always @(posedge clk) begin
    if (io.m_we)
      for (int b = 0; b < 4; b++)
        if (io.m_bmsk[b]) mem[io.m_ai][8*b +: 8] <= io.m_vi[8*b +: 8];
    io.m_vo <= mem[io.m_ai];
  end

  // Reference: a transfer of bytes d[i] to (base+i) mod 2^AW
  task automatic model_write(input logic [AW-1:0] b);
    for (int i = 0; i < wq.size(); i++) begin
      wr_t e;
      e.addr = b + AW'(i);
      e.b    = wq[i];
      e.ai   = e.addr / 4;
      e.bmsk = 4'(1 << (e.addr % 4));
      e.vi   = {e.b, e.b, e.b, e.b};
      exp_wr.push_back(e);
    end
  endtask

  task automatic model_read(input logic [AW-1:0] b, input int l);
    for (int i = 0; i < l; i++) begin
      logic [AW-1:0] a;
      a = b + AW'(i);
      exp_rd.push_back(refm[a]);
    end
  endtask

  always @(negedge clk) begin
    if (io.m_we) begin
      wr_t d;
      d.ai = io.m_ai; d.bmsk = io.m_bmsk; d.vi = io.m_vi; d.addr = '0; d.b = '0;
      dut_wr.push_back(d);
      if (exp_wr.size() == 0) bad("unexpected_write");
      else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_ai", io.m_ai, e.ai);
        chk("wr_bmsk", io.m_bmsk, e.bmsk);
        chk("wr_vi", io.m_vi, e.vi);
        refm[e.addr] = e.b;
      end
    end else if (busy) chk("bmsk_no_we", io.m_bmsk, 0);
    if (io.so_valid) begin
      if (exp_rd.size() == 0) bad("unexpected_so_valid");
      else begin
        chk("so_data", io.so_data, exp_rd[0]);
        if (io.so_ready) begin
          dut_so.push_back(io.so_data);
          void'(exp_rd.pop_front());
        end
      end
    end
    if (err) chk("err_with_done", done, 1);
    if (done) n_done++;
    if (err) n_err++;
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_si_ready"}, io.si_ready, 0);
    chk({tag, "_so_valid"}, io.so_valid, 0);
    chk({tag, "_so_data"}, io.so_data, 0);
    chk({tag, "_m_we"}, io.m_we, 0);
    chk({tag, "_m_bmsk"}, io.m_bmsk, 0);
    chk({tag, "_m_ai"}, io.m_ai, 0);
    chk({tag, "_m_vi"}, io.m_vi, 0);
  endtask

  task automatic kick(input logic m, input logic [AW-1:0] b, input logic [AW-1:0] l);
    start = 1'b1; mode = m; base = b; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit poke);
    bit rdy;
    int tries;
    si_valid_set(d);
    if (poke) begin start = 1'b1; mode = 1'b1; base = '0; len = '0; end
    tries = 0;
    do begin
      @(negedge clk); rdy = io.si_ready;
      @(posedge clk); #1;
      start = 1'b0;
      tries++;
    end while (!rdy && tries < 10);
    if (!rdy) bad("si_ready_timeout");
  endtask

  task automatic si_valid_set(input logic [7:0] d);
    io.si_valid = 1'b1;
    io.si_data  = d;
  endtask

  task automatic do_wr(input logic [AW-1:0] b, input int gaps, input bit poke);
    model_write(b);
    kick(1'b0, b, AW'(wq.size()));
    chk("wr_busy", busy, 1);
    for (int i = 0; i < wq.size(); i++) begin
      if (gaps[i]) begin
        io.si_valid = 1'b0;
        @(posedge clk); #1;
      end
      send_byte(wq[i], poke && i == 1);
    end
    io.si_valid = 1'b0;
    chk("wr_done_after_last", done, 1);
    exp_done++;
    @(posedge clk); #1;
    chk("wr_done_one_cycle", done, 0);
    chk("wr_busy_cleared", busy, 0);
    chk("wr_queue_drained", exp_wr.size(), 0);
  endtask

  task automatic do_zero(input logic m, input bit err_exp);
    kick(m, AW'('h123), '0);
    chk("zlen_done", done, 1);
    chk("zlen_err", err, err_exp);
    exp_done++;
    if (err_exp) exp_err++;
    @(posedge clk); #1;
    chk("zlen_busy_cleared", busy, 0);
  endtask

`ifdef MB32_READBACK_EN
  task automatic preload();
    mem[1] = 32'h44332211;
    mem[2] = 32'h88776655;
    for (int i = 0; i < 4; i++) begin
      refm[4 + i] = mem[1][8*i +: 8];
      refm[8 + i] = mem[2][8*i +: 8];
    end
  endtask

  task automatic do_rd(input logic [AW-1:0] b, input int l, input bit toggle, output int cyc);
    int k;
    model_read(b, l);
    kick(1'b1, b, AW'(l));
    cyc = 0;
    k = 0;
    while (!done && cyc < 100) begin
      io.so_ready = toggle ? (k % 2 == 0) : 1'b1;
      k++;
      @(posedge clk); #1;
      cyc++;
    end
    io.so_ready = 1'b0;
    chk("rd_done_seen", done, 1);
    exp_done++;
    chk("rd_all_bytes", exp_rd.size(), 0);
    @(posedge clk); #1;
    chk("rd_busy_cleared", busy, 0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0;
    rst = 1'b1; start = 1'b0; mode = 1'b0; base = '0; len = '0;
    io.si_valid = 1'b0; io.si_data = '0; io.so_ready = 1'b0;
    for (int i = 0; i < (1 << (AW-2)); i++) mem[i] = '0;
    for (int i = 0; i < (1 << AW); i++) refm[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // base 5, three bytes into lanes 1..3 of word 1
    w0 = dut_wr.size();
    wq = '{8'hA1, 8'hB2, 8'hC3};
    do_wr(AW'('h5), 0, 1'b0);
    chk("w1_count", dut_wr.size() - w0, 3);
    chk("w1_ai0", dut_wr[w0].ai, 15'd1);
    chk("w1_bmsk0", dut_wr[w0].bmsk, 4'b0010);
    chk("w1_vi0", dut_wr[w0].vi, 32'hA1A1A1A1);
    chk("w1_bmsk1", dut_wr[w0+1].bmsk, 4'b0100);
    chk("w1_bmsk2", dut_wr[w0+2].bmsk, 4'b1000);
    chk("w1_ai2", dut_wr[w0+2].ai, 15'd1);
    chk("w1_mem", mem[1], 32'hC3B2A100);

    // valid gaps and a start pulse during the transfer that must be ignored
    wq = '{8'h10, 8'h22, 8'h34, 8'h46, 8'h58, 8'h6A};
    do_wr(AW'('h20), 32'b010100, 1'b1);
    chk("w2_mem_lo", mem[8], 32'h46342210);
    chk("w2_mem_hi", mem[9], 32'h00006A58);

    // address wrap at the top of memory
    w0 = dut_wr.size();
    wq = '{8'h5A, 8'hC3};
    do_wr(AW'('h1FFFF), 0, 1'b0);
    chk("wrap_ai0", dut_wr[w0].ai, 15'h7FFF);
    chk("wrap_bmsk0", dut_wr[w0].bmsk, 4'b1000);
    chk("wrap_ai1", dut_wr[w0+1].ai, 15'h0000);
    chk("wrap_bmsk1", dut_wr[w0+1].bmsk, 4'b0001);

    do_zero(1'b0, 1'b0);
`ifdef MB32_READBACK_EN
    do_zero(1'b1, 1'b0);
    begin
      int cyc;
      preload();
      w0 = dut_so.size();
      do_rd(AW'('h6), 4, 1'b0, cyc);
      chk("rd_latency_two_req", cyc, 8);
      chk("rd_b0", dut_so[w0], 8'h33);
      chk("rd_b1", dut_so[w0+1], 8'h44);
      chk("rd_b2", dut_so[w0+2], 8'h55);
      chk("rd_b3", dut_so[w0+3], 8'h66);
      w0 = dut_so.size();
      do_rd(AW'('h6), 4, 1'b1, cyc);
      chk("bp_count", dut_so.size() - w0, 4);
      chk("bp_b3", dut_so[w0+3], 8'h66);
    end
`else
    do_zero(1'b1, 1'b1);
    w0 = dut_wr.size();
    kick(1'b1, AW'('h6), AW'(4));
    chk("unsup_done", done, 1);
    chk("unsup_err", err, 1);
    exp_done++; exp_err++;
    @(posedge clk); #1;
    chk("unsup_busy_cleared", busy, 0);
    chk("unsup_no_bus", dut_wr.size() - w0, 0);
`endif

    // reset after two of five bytes
    w0 = dut_wr.size();
    wq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    model_write(AW'('h40));
    kick(1'b0, AW'('h40), AW'(5));
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    io.si_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_wr.delete();
    chk_zero("abort");
    rst = 1'b0;
    si_valid_set(8'h03);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_si_ready", io.si_ready, 0);
    end
    io.si_valid = 1'b0;
    chk("abort_writes", dut_wr.size() - w0, 2);

    // recovery after abort
    wq = '{8'hEE};
    do_wr(AW'('h3), 0, 1'b0);
    chk("recover_mem", mem[0][31:24], 8'hEE);

    repeat (2) @(posedge clk);
    #1;
    chk("done_pulses", n_done, exp_done);
    chk("err_pulses", n_err, exp_err);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mb32_stream_dma.md
MB32_STREAM_DMA -- requirements
Module: mb32_stream_dma

Interface
REQ-001 Parameter AW, default 17, byte-address width covering the 128 KB (32K x 32-bit) memory.
REQ-002 clk  in  1  single system clock, all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  one-cycle transfer request, sampled only in IDLE.
REQ-005 mode  in  1  0 = stream-to-memory write, 1 = memory-to-stream read.
REQ-006 base  in  AW  starting byte address, latched on accepted start.
REQ-007 len  in  AW  byte count, latched on accepted start; 0 is legal.
REQ-008 si_valid / si_data / si_ready  in / in 8 / out  inbound byte stream, valid/ready handshake.
REQ-009 so_valid / so_data / so_ready  out / out 8 / in  outbound byte stream, valid/ready handshake.
REQ-010 busy  out  1  high from the cycle after accepted start until done.
REQ-011 done  out  1  one-cycle pulse at transfer end.
REQ-012 err  out  1  one-cycle pulse with done when the request was unsupported.
REQ-013 m_ai / m_vi / m_bmsk / m_we  out 15 / 32 / 4 / 1  master side of the 32-bit mb_io bus (word address, write data, byte mask, write enable).
REQ-014 m_vo  in  32  read data from the mb_io slave, valid one clk after the address is presented.

Function
REQ-015 FSM states: IDLE, WRITE, RD_REQ, RD_LAT, RD_OUT, FIN.
REQ-016 IDLE + start: latch ptr=base, cnt=len; go to FIN if len=0, else WRITE (mode=0) or RD_REQ (mode=1).
REQ-017 start while busy shall be ignored.
REQ-018 WRITE: si_ready=1; on si_valid&si_ready drive in the same cycle m_we=1, m_ai=ptr[AW-1:2], m_bmsk=one-hot(ptr[1:0]), m_vi={4{si_data}}; ptr+1, cnt-1.
REQ-019 Throughput in WRITE: one byte per clk; no bus write without a handshake.
REQ-020 Byte lane: little-endian, byte at ptr[1:0]=k occupies m_vi[8k+7:8k].
REQ-021 RD_REQ: drive m_ai=ptr[AW-1:2], m_we=0, go to RD_LAT; RD_LAT: capture m_vo into word register, go to RD_OUT.
REQ-022 RD_OUT: so_valid=1, so_data=word lane ptr[1:0]; on so_ready: ptr+1, cnt-1; if cnt becomes 0 go FIN, else if new ptr[1:0]=0 go RD_REQ, else stay.
REQ-023 so_data shall hold stable while so_valid=1 and so_ready=0.
REQ-024 FIN: done=1 for one cycle, busy=0 next cycle, return to IDLE.
REQ-025 In WRITE, when cnt reaches 0 after a handshake, next state FIN; si_ready low in FIN.
REQ-026 ptr shall wrap modulo 2^AW (0x1FFFF+1 -> 0x00000); cnt arithmetic AW-bit unsigned, no underflow possible.
REQ-027 m_we shall be 0 in every state except a WRITE handshake cycle; m_bmsk=0 when m_we=0.

Reset
REQ-028 rst high at a clk edge: state IDLE, ptr=0, cnt=0, all outputs 0 (busy, done, err, si_ready, so_valid, m_we, m_bmsk, m_ai, m_vi, so_data).
REQ-029 rst mid-transfer aborts immediately; no done pulse, no further bus writes.

Configuration
REQ-030 Macro MB32_READBACK_EN: defined -> read path (RD_REQ, RD_LAT, RD_OUT) compiled in, err never asserts.
REQ-031 Not defined -> read states absent, so_valid tied 0, so_data 0; start with mode=1 goes straight to FIN, pulsing done and err together, no bus access.

Verification
REQ-032 Write: base=0x00005, len=3, bytes A1,B2,C3 -> writes ai=1 bmsk=0010 vi=A1A1A1A1, ai=1 bmsk=0100, ai=1 bmsk=1000; done 1 clk after last.
REQ-033 Read: memory word1=0x44332211, word2=0x88776655, base=0x00006, len=4, so_ready=1 -> so_data 33,44,55,66; exactly two RD_REQ cycles.
REQ-034 Backpressure: read with so_ready toggling 1010 -> every byte emitted once, so_data stable while stalled.
REQ-035 Wrap: write base=0x1FFFF, len=2 -> ai=0x7FFF bmsk=1000, then ai=0x0000 bmsk=0001.
REQ-036 len=0 either mode -> done pulse 1-2 clk after start, no m_we, no so_valid.
REQ-037 rst asserted after 2 of 5 write bytes -> all outputs 0 next clk, no done; macro off: mode=1 start -> done and err same cycle.
